// File: rtl/shake256_msg_feeder_pkg.sv
// Shared constants, FSM encoding and byte-count helper for the SHAKE256
// message feeder.
package shake256_msg_feeder_pkg;

    localparam int RATE_BITS  = 1088;
    localparam int RATE_BYTES = 136;
    localparam int WORD_BITS  = 64;
    localparam int LEN_W      = 11;
    localparam int BLKNUM_W   = 4;

    // FSM state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] ISSUE  = 2'd2;
    localparam logic [1:0] PADBLK = 2'd3;

    // Number of valid bytes in a last word; an encoding of 0 means a full word.
    function automatic logic [3:0] eff_bytes(input logic [3:0] b);
        return ((b == 4'd0) || (b > 4'd8)) ? 4'd8 : b;
    endfunction

endpackage

// File: rtl/shake256_msg_feeder_byte_mask.sv
// Zeroes the bytes of a final message word that lie beyond its valid byte
// count. Byte 0 is the most significant byte of the word.
module feeder_byte_mask
    import shake256_msg_feeder_pkg::*;
(
    input  logic [WORD_BITS-1:0] data_i,
    input  logic                 last_i,
    input  logic [3:0]           bytes_i,
    output logic [WORD_BITS-1:0] data_o
);

    logic [3:0] nb;

    // Clear trailing bytes only on the last word of a message
    always_comb begin
        nb     = eff_bytes(bytes_i);
        data_o = data_i;
        if (last_i) begin
            for (int b = 0; b < 8; b++) begin
                if (b >= int'(nb)) begin
                    data_o[WORD_BITS-1-8*b -: 8] = 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/shake256_msg_feeder.sv
// SHAKE256 absorb front end: packs a 64-bit ready/valid message stream into
// 1088-bit rate blocks and issues each block to the pipeline with a one-cycle
// en strobe, respecting a minimum issue spacing and core_ready. A message
// whose length is a whole number of blocks gets an extra all-padding block.
// Optional macro FEEDER_STATS_EN adds stat_blocks / stat_msgs counters.
module shake256_msg_feeder
    import shake256_msg_feeder_pkg::*;
#(
    parameter int RATE_WORDS = 17,
    parameter int ISSUE_GAP  = 24
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_BITS-1:0]  s_data,
    input  logic                  s_last,
    input  logic [3:0]            s_bytes,
    input  logic                  core_ready,
    output logic                  en,
    output logic [RATE_BITS-1:0]  s_in,
    output logic [LEN_W-1:0]      len,
    output logic [BLKNUM_W-1:0]   block_num,
    output logic                  busy
`ifdef FEEDER_STATS_EN
    ,
    output logic [31:0]           stat_blocks,
    output logic [31:0]           stat_msgs
`endif
);

    localparam int GAP_W  = $clog2(ISSUE_GAP + 1);
    localparam int WCNT_W = $clog2(RATE_WORDS + 1);

    logic [1:0]           state_q, state_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [7:0]           bytes_q, bytes_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 last_q, last_d;
    logic [RATE_BITS-1:0] buf_q, buf_d;
    logic [BLKNUM_W-1:0]  bcnt_q, bcnt_d;
    logic [RATE_BITS-1:0] sin_q, sin_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [BLKNUM_W-1:0]  bn_q, bn_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 run_q;
    logic                 msg_done_d;

    logic [WORD_BITS-1:0] word_masked;
    logic [3:0]           word_bytes;
    logic                 accept;
    logic                 issue_ok;

    feeder_byte_mask u_mask (
        .data_i  (s_data),
        .last_i  (s_last),
        .bytes_i (s_bytes),
        .data_o  (word_masked)
    );

    assign s_ready   = run_q & ((state_q == IDLE) | (state_q == FILL));
    assign accept    = s_valid & s_ready;
    assign word_bytes = s_last ? eff_bytes(s_bytes) : 4'd8;
    assign issue_ok  = (gap_q == '0) & core_ready;

    assign en        = en_q;
    assign s_in      = sin_q;
    assign len       = len_q;
    assign block_num = bn_q;
    assign busy      = busy_q;

    // Next-state logic for packing, issue timing and block numbering
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        bytes_d    = bytes_q;
        gap_d      = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        last_d     = last_q;
        buf_d      = buf_q;
        bcnt_d     = bcnt_q;
        sin_d      = sin_q;
        len_d      = len_q;
        bn_d       = bn_q;
        en_d       = 1'b0;
        busy_d     = busy_q;
        msg_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d   = {word_masked, {(RATE_BITS-WORD_BITS){1'b0}}};
                    wcnt_d  = WCNT_W'(1);
                    bytes_d = {4'b0000, word_bytes};
                    last_d  = s_last;
                    busy_d  = 1'b1;
                    state_d = s_last ? ISSUE : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < RATE_WORDS; k++) begin
                        if (wcnt_q == WCNT_W'(k)) begin
                            buf_d[RATE_BITS-1-WORD_BITS*k -: WORD_BITS] = word_masked;
                        end
                    end
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                    bytes_d = bytes_q + {4'b0000, word_bytes};
                    last_d  = s_last;
                    if (s_last || (wcnt_q == WCNT_W'(RATE_WORDS-1))) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue_ok) begin
                    en_d    = 1'b1;
                    sin_d   = buf_q;
                    len_d   = {bytes_q, 3'b000};
                    bn_d    = bcnt_q;
                    gap_d   = GAP_W'(ISSUE_GAP-1);
                    buf_d   = '0;
                    wcnt_d  = '0;
                    bytes_d = '0;
                    if (last_q && (bytes_q == 8'(RATE_BYTES))) begin
                        // Message filled the block exactly: padding needs its own block
                        bcnt_d  = bcnt_q + BLKNUM_W'(1);
                        state_d = PADBLK;
                    end else if (last_q) begin
                        bcnt_d     = '0;
                        busy_d     = 1'b0;
                        last_d     = 1'b0;
                        msg_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        bcnt_d  = bcnt_q + BLKNUM_W'(1);
                        state_d = FILL;
                    end
                end
            end
            default: begin
                if (issue_ok) begin
                    en_d       = 1'b1;
                    sin_d      = '0;
                    len_d      = '0;
                    bn_d       = bcnt_q;
                    gap_d      = GAP_W'(ISSUE_GAP-1);
                    bcnt_d     = '0;
                    busy_d     = 1'b0;
                    last_d     = 1'b0;
                    msg_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
        endcase
    end

    // State, packing buffer and held output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            bytes_q <= '0;
            gap_q   <= '0;
            last_q  <= 1'b0;
            buf_q   <= '0;
            bcnt_q  <= '0;
            sin_q   <= '0;
            len_q   <= '0;
            bn_q    <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            bytes_q <= bytes_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            buf_q   <= buf_d;
            bcnt_q  <= bcnt_d;
            sin_q   <= sin_d;
            len_q   <= len_d;
            bn_q    <= bn_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            run_q   <= 1'b1;
        end
    end

`ifdef FEEDER_STATS_EN
    logic [31:0] stat_blocks_q;
    logic [31:0] stat_msgs_q;

    // Free-running block and message counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_blocks_q <= '0;
            stat_msgs_q   <= '0;
        end else begin
            if (en_d)       stat_blocks_q <= stat_blocks_q + 32'd1;
            if (msg_done_d) stat_msgs_q   <= stat_msgs_q + 32'd1;
        end
    end

    assign stat_blocks = stat_blocks_q;
    assign stat_msgs   = stat_msgs_q;
`endif

endmodule

// File: tb/tb_shake256_msg_feeder.sv
// Self-checking bench for shake256_msg_feeder: table of message lengths with
// hand-derived block counts, randomized messages checked against a byte-level
// reference model, and hand sequences for stall, gap and reset corner cases.
module tb_shake256_msg_feeder;

    localparam int GAP = 24;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [63:0]   s_data = '0;
    logic          s_last = 1'b0;
    logic [3:0]    s_bytes = '0;
    logic          core_ready = 1'b1;
    logic          en;
    logic [1087:0] s_in;
    logic [10:0]   len;
    logic [3:0]    block_num;
    logic          busy;
`ifdef FEEDER_STATS_EN
    logic [31:0]   stat_blocks;
    logic [31:0]   stat_msgs;
`endif

    shake256_msg_feeder #(.RATE_WORDS(17), .ISSUE_GAP(GAP)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_bytes    (s_bytes),
        .core_ready (core_ready),
        .en         (en),
        .s_in       (s_in),
        .len        (len),
        .block_num  (block_num),
        .busy       (busy)
`ifdef FEEDER_STATS_EN
        ,
        .stat_blocks(stat_blocks),
        .stat_msgs  (stat_msgs)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Captured block issues
    logic [1087:0] got_sin[$];
    int            got_len[$];
    int            got_bn[$];
    int            got_cyc[$];

    always @(negedge clk) begin
        if (en === 1'b1) begin
            got_sin.push_back(s_in);
            got_len.push_back(int'(len));
            got_bn.push_back(int'(block_num));
            got_cyc.push_back(cyc);
        end
    end

    // Reference model state: message bytes and expected blocks
    logic [7:0]    msg[$];
    logic [1087:0] exp_sin[$];
    int            exp_len[$];
    int            exp_bn[$];

    typedef struct {
        int nbytes;
        int exp_n;
        int exp_last_len;
        int exp_last_bn;
        int idle_max;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [1087:0] act, input logic [1087:0] exp);
        logic found;
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            found = 1'b0;
            for (int k = 0; k < 17; k++) begin
                if (!found && (act[1087-64*k -: 64] !== exp[1087-64*k -: 64])) begin
                    found = 1'b1;
                    $display("FAIL %s word %0d: got %h expected %h", name, k,
                             act[1087-64*k -: 64], exp[1087-64*k -: 64]);
                end
            end
        end
    endtask

    // Split a message into rate blocks by byte count; an exact multiple of
    // 136 bytes is followed by an empty block.
    task automatic build_expect();
        int n;
        int nblk;
        int cnt;
        logic [1087:0] blk;
        exp_sin.delete(); exp_len.delete(); exp_bn.delete();
        n    = msg.size();
        nblk = n / 136 + 1;
        for (int b = 0; b < nblk; b++) begin
            cnt = n - 136 * b;
            if (cnt > 136) cnt = 136;
            if (cnt < 0) cnt = 0;
            blk = '0;
            for (int j = 0; j < cnt; j++) blk[1087-8*j -: 8] = msg[136*b + j];
            exp_sin.push_back(blk);
            exp_len.push_back(8 * cnt);
            exp_bn.push_back(b % 16);
        end
    endtask

    // Present one word and hold it until accepted; called and returns at negedge
    task automatic drive_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int t;
        t = 0;
        s_data = d; s_last = last; s_bytes = nb; s_valid = 1'b1;
        while (s_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("s_ready_timeout", 64'(t), 64'd0);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Generate a random message, compute its expected blocks, and stream it in
    task automatic send_msg(input int nbytes, input int idle_max);
        int nw;
        int idx;
        int rem;
        logic [63:0] w;
        logic [3:0]  nb;
        msg.delete();
        for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
        build_expect();
        got_sin.delete(); got_len.delete(); got_bn.delete(); got_cyc.delete();
        nw = (nbytes + 7) / 8;
        for (int wi = 0; wi < nw; wi++) begin
            for (int b = 0; b < 8; b++) begin
                idx = wi * 8 + b;
                w[63-8*b -: 8] = (idx < nbytes) ? msg[idx] : (8'($urandom) | 8'h80);
            end
            rem = nbytes - 8 * wi;
            nb  = (rem >= 8) ? (($urandom_range(0, 1) == 0) ? 4'd0 : 4'd8) : 4'(rem);
            drive_word(w, wi == nw - 1, nb);
            if (wi == 0) chk("busy_after_first_word", 64'(busy), 64'd1);
            if (wi != nw - 1 && idle_max > 0) begin
                repeat ($urandom_range(0, idle_max)) @(negedge clk);
            end
        end
    endtask

    // Wait for the expected block count, then compare every block with the model
    task automatic collect_and_check(input string tag);
        int t;
        t = 0;
        while (got_len.size() < exp_len.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (GAP + 5) @(negedge clk);
        chk({tag, "_nblocks"}, 64'(got_len.size()), 64'(exp_len.size()));
        for (int b = 0; b < exp_len.size() && b < got_len.size(); b++) begin
            chk({tag, "_len"}, 64'(got_len[b]), 64'(exp_len[b]));
            chk({tag, "_bn"}, 64'(got_bn[b]), 64'(exp_bn[b]));
            chk_blk({tag, "_sin"}, got_sin[b], exp_sin[b]);
            if (b > 0) begin
                n_cmp++;
                if (got_cyc[b] - got_cyc[b-1] < GAP) begin
                    n_bad++;
                    $display("FAIL %s_gap: spacing %0d cycles, required at least %0d",
                             tag, got_cyc[b] - got_cyc[b-1], GAP);
                end
            end
        end
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        chk({tag, "_ready_done"}, 64'(s_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"}, 64'(en), 64'd0);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_len"}, 64'(len), 64'd0);
        chk({tag, "_bn"}, 64'(block_num), 64'd0);
        chk_blk({tag, "_sin"}, s_in, '0);
    endtask

    initial begin
        int bad_cycles;
        int nr;
        logic [63:0] w;

        tbl[0] = '{21,   1,  168, 0, 0};
        tbl[1] = '{272,  3,  0,   2, 0};
        tbl[2] = '{160,  2,  192, 1, 2};
        tbl[3] = '{8,    1,  64,  0, 0};
        tbl[4] = '{136,  2,  0,   1, 3};
        tbl[5] = '{137,  2,  8,   1, 1};
        tbl[6] = '{1,    1,  8,   0, 0};
        tbl[7] = '{2176, 17, 0,   0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_reset", 64'(s_ready), 64'd1);

        // Table of message lengths
        for (int i = 0; i < 8; i++) begin
            send_msg(tbl[i].nbytes, tbl[i].idle_max);
            collect_and_check($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_count", i), 64'(got_len.size()), 64'(tbl[i].exp_n));
            if (got_len.size() > 0) begin
                chk($sformatf("tbl%0d_last_len", i), 64'(got_len[got_len.size()-1]), 64'(tbl[i].exp_last_len));
                chk($sformatf("tbl%0d_last_bn", i), 64'(got_bn[got_bn.size()-1]), 64'(tbl[i].exp_last_bn));
            end
        end

        // 20-word message: ready stays low while the second block waits on the gap
        send_msg(160, 0);
        chk("gap_wait_s_ready", 64'(s_ready), 64'd0);
        chk("gap_wait_en", 64'(en), 64'd0);
        chk("gap_wait_one_issued", 64'(got_len.size()), 64'd1);
        collect_and_check("gap20");

        // core_ready held low at ISSUE
        core_ready = 1'b0;
        send_msg(5, 0);
        bad_cycles = 0;
        repeat (50) begin
            @(negedge clk);
            if (en !== 1'b0 || s_ready !== 1'b0) bad_cycles++;
        end
        chk("stall_bad_cycles", 64'(bad_cycles), 64'd0);
        core_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_en", 64'(en), 64'd1);
        collect_and_check("stall");

        // Reset in the middle of a block
        got_sin.delete(); got_len.delete(); got_bn.delete(); got_cyc.delete();
        for (int i = 0; i < 7; i++) drive_word(64'($urandom) << 32 | 64'($urandom), 1'b0, 4'd8);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_no_en", 64'(got_len.size()), 64'd0);
        send_msg(1, 0);
        collect_and_check("after_rst");
        if (got_len.size() > 0) begin
            chk("after_rst_len", 64'(got_len[0]), 64'd8);
            chk("after_rst_bn", 64'(got_bn[0]), 64'd0);
        end

        // Randomized messages against the model
        for (int r = 0; r < 10; r++) begin
            nr = $urandom_range(1, 420);
            send_msg(nr, 2);
            collect_and_check($sformatf("rand%0d_n%0d", r, nr));
        end

`ifdef FEEDER_STATS_EN
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        send_msg(272, 0);
        collect_and_check("stats272");
        send_msg(21, 0);
        collect_and_check("stats21");
        chk("stat_blocks", 64'(stat_blocks), 64'd4);
        chk("stat_msgs", 64'(stat_msgs), 64'd2);
`endif

        w = '0;
        s_data = w;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
